// File: rtl/milestone3_dequant_writer.sv
// Dequantizes zig-zag ordered coefficients and writes them de-zig-zagged into the pre-IDCT
// SRAM region, walking Y, then U, then V blocks. Optional macro: DEQ_SATURATE_EN (saturating dequant).
module milestone3_dequant_writer #(
   parameter logic [17:0] PRE_IDCT_BASE = 18'd76800,
   parameter logic [17:0] Y_STRIDE      = 18'd320,
   parameter logic [17:0] UV_STRIDE     = 18'd160,
   // frame geometry in 8x8 blocks
   parameter int unsigned Y_BLK_COLS    = 40,
   parameter int unsigned UV_BLK_COLS   = 20,
   parameter int unsigned BLK_ROWS      = 30
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Enable,
   input  logic        Q_select,
   input  logic        coeff_valid,
   input  logic [15:0] coeff_data,
   output logic        coeff_ready,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   output logic        Done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   localparam logic [1:0] SEG_Y = 2'd0;
   localparam logic [1:0] SEG_U = 2'd1;
   localparam logic [1:0] SEG_V = 2'd2;

   localparam logic [5:0] Y_COL_LAST  = 6'(Y_BLK_COLS - 1);
   localparam logic [5:0] UV_COL_LAST = 6'(UV_BLK_COLS - 1);
   localparam logic [4:0] ROW_LAST    = 5'(BLK_ROWS - 1);

   localparam logic [17:0] U_BASE = PRE_IDCT_BASE + 18'd76800;
   localparam logic [17:0] V_BASE = PRE_IDCT_BASE + 18'd115200;

   // Standard JPEG zig-zag: index k -> natural position r*8+c
   function automatic logic [5:0] zz_pos(input logic [5:0] k);
      logic [5:0] p;
      case (k)
         6'd0:  p = 6'd0;   6'd1:  p = 6'd1;   6'd2:  p = 6'd8;   6'd3:  p = 6'd16;
         6'd4:  p = 6'd9;   6'd5:  p = 6'd2;   6'd6:  p = 6'd3;   6'd7:  p = 6'd10;
         6'd8:  p = 6'd17;  6'd9:  p = 6'd24;  6'd10: p = 6'd32;  6'd11: p = 6'd25;
         6'd12: p = 6'd18;  6'd13: p = 6'd11;  6'd14: p = 6'd4;   6'd15: p = 6'd5;
         6'd16: p = 6'd12;  6'd17: p = 6'd19;  6'd18: p = 6'd26;  6'd19: p = 6'd33;
         6'd20: p = 6'd40;  6'd21: p = 6'd48;  6'd22: p = 6'd41;  6'd23: p = 6'd34;
         6'd24: p = 6'd27;  6'd25: p = 6'd20;  6'd26: p = 6'd13;  6'd27: p = 6'd6;
         6'd28: p = 6'd7;   6'd29: p = 6'd14;  6'd30: p = 6'd21;  6'd31: p = 6'd28;
         6'd32: p = 6'd35;  6'd33: p = 6'd42;  6'd34: p = 6'd49;  6'd35: p = 6'd56;
         6'd36: p = 6'd57;  6'd37: p = 6'd50;  6'd38: p = 6'd43;  6'd39: p = 6'd36;
         6'd40: p = 6'd29;  6'd41: p = 6'd22;  6'd42: p = 6'd15;  6'd43: p = 6'd23;
         6'd44: p = 6'd30;  6'd45: p = 6'd37;  6'd46: p = 6'd44;  6'd47: p = 6'd51;
         6'd48: p = 6'd58;  6'd49: p = 6'd59;  6'd50: p = 6'd52;  6'd51: p = 6'd45;
         6'd52: p = 6'd38;  6'd53: p = 6'd31;  6'd54: p = 6'd39;  6'd55: p = 6'd46;
         6'd56: p = 6'd53;  6'd57: p = 6'd60;  6'd58: p = 6'd61;  6'd59: p = 6'd54;
         6'd60: p = 6'd47;  6'd61: p = 6'd55;  6'd62: p = 6'd62;  6'd63: p = 6'd63;
         default: p = 6'd63;
      endcase
      return p;
   endfunction

   // Shift amount indexed by diagonal r+c for the selected quant matrix
   function automatic logic [2:0] deq_shift(input logic q, input logic [3:0] diag);
      logic [2:0] s;
      if (!q) begin
         case (diag)
            4'd0:        s = 3'd3;
            4'd1:        s = 3'd2;
            4'd2:        s = 3'd3;
            4'd3:        s = 3'd4;
            4'd4, 4'd5:  s = 3'd5;
            default:     s = 3'd6;
         endcase
      end else begin
         case (diag)
            4'd0:              s = 3'd3;
            4'd1, 4'd2, 4'd3:  s = 3'd1;
            4'd4, 4'd5:        s = 3'd2;
            4'd6, 4'd7:        s = 3'd3;
            4'd8, 4'd9, 4'd10: s = 3'd4;
            default:           s = 3'd5;
         endcase
      end
      return s;
   endfunction

   function automatic logic [15:0] dequant(input logic [15:0] d, input logic [2:0] s);
      logic [15:0] res;
`ifdef DEQ_SATURATE_EN
      logic signed [22:0] wide;
      wide = $signed({{7{d[15]}}, d}) <<< s;
      if (wide > 23'sd32767) begin
         res = 16'h7FFF;
      end else if (wide < -23'sd32768) begin
         res = 16'h8000;
      end else begin
         res = wide[15:0];
      end
`else
      res = d << s;
`endif
      return res;
   endfunction

   state_t      state_r, next_state_s;
   logic        q_sel_r;
   logic [5:0]  k_r;
   logic [5:0]  blk_col_r;
   logic [4:0]  blk_row_r;
   logic [1:0]  seg_r;
   logic        ready_r;
   logic        done_r;
   logic [17:0] addr_r;
   logic [15:0] data_r;
   logic        we_n_r;

   logic        xfer_s;
   logic        k_last_s, col_last_s, row_last_s, seg_last_s, last_coeff_s;
   logic [5:0]  col_limit_s;
   logic [5:0]  pos_s;
   logic [2:0]  r_s, c_s;
   logic [3:0]  diag_s;
   logic [7:0]  pix_row_s;
   logic [8:0]  pix_col_s;
   logic [17:0] seg_base_s, stride_off_s, addr_s;
   logic [15:0] deq_s;

   assign xfer_s       = coeff_valid & ready_r;
   assign col_limit_s  = (seg_r == SEG_Y) ? Y_COL_LAST : UV_COL_LAST;
   assign k_last_s     = (k_r == 6'd63);
   assign col_last_s   = (blk_col_r == col_limit_s);
   assign row_last_s   = (blk_row_r == ROW_LAST);
   assign seg_last_s   = (seg_r == SEG_V);
   assign last_coeff_s = k_last_s & col_last_s & row_last_s & seg_last_s;

   assign pos_s     = zz_pos(k_r);
   assign r_s       = pos_s[5:3];
   assign c_s       = pos_s[2:0];
   assign diag_s    = {1'b0, r_s} + {1'b0, c_s};
   assign pix_row_s = {blk_row_r, r_s};
   assign pix_col_s = {blk_col_r, c_s};
   assign deq_s     = dequant(coeff_data, deq_shift(q_sel_r, diag_s));

   // Segment base and row offset for the current write
   always_comb begin
      seg_base_s   = PRE_IDCT_BASE;
      stride_off_s = 18'(pix_row_s) * Y_STRIDE;
      case (seg_r)
         SEG_Y: begin
            seg_base_s   = PRE_IDCT_BASE;
            stride_off_s = 18'(pix_row_s) * Y_STRIDE;
         end
         SEG_U: begin
            seg_base_s   = U_BASE;
            stride_off_s = 18'(pix_row_s) * UV_STRIDE;
         end
         SEG_V: begin
            seg_base_s   = V_BASE;
            stride_off_s = 18'(pix_row_s) * UV_STRIDE;
         end
         default: begin
            seg_base_s   = PRE_IDCT_BASE;
            stride_off_s = 18'(pix_row_s) * Y_STRIDE;
         end
      endcase
   end

   assign addr_s = seg_base_s + stride_off_s + 18'(pix_col_s);

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (Enable) next_state_s = S_RUN;
            else        next_state_s = S_IDLE;
         end
         S_RUN: begin
            if (xfer_s && last_coeff_s) next_state_s = S_FLUSH;
            else                        next_state_s = S_RUN;
         end
         S_FLUSH: next_state_s = S_DONE;
         S_DONE:  next_state_s = S_IDLE;
         default: next_state_s = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) state_r <= S_IDLE;
      else       state_r <= next_state_s;
   end

   // Handshake and completion flags, registered from the next state
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ready_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         ready_r <= (next_state_s == S_RUN);
         done_r  <= (next_state_s == S_DONE);
      end
   end

   // Frame position counters: k within block, then block column, row, segment
   always_ff @(posedge Clock) begin
      if (Reset) begin
         q_sel_r   <= 1'b0;
         k_r       <= 6'd0;
         blk_col_r <= 6'd0;
         blk_row_r <= 5'd0;
         seg_r     <= SEG_Y;
      end else if ((state_r == S_IDLE) && Enable) begin
         q_sel_r   <= Q_select;
         k_r       <= 6'd0;
         blk_col_r <= 6'd0;
         blk_row_r <= 5'd0;
         seg_r     <= SEG_Y;
      end else if (xfer_s) begin
         k_r <= k_r + 6'd1;
         if (k_last_s) begin
            if (col_last_s) begin
               blk_col_r <= 6'd0;
               if (row_last_s) begin
                  blk_row_r <= 5'd0;
                  if (seg_last_s) seg_r <= SEG_Y;
                  else            seg_r <= seg_r + 2'd1;
               end else begin
                  blk_row_r <= blk_row_r + 5'd1;
               end
            end else begin
               blk_col_r <= blk_col_r + 6'd1;
            end
         end
      end
   end

   // Single write pipeline stage; a reset drops any pending write
   always_ff @(posedge Clock) begin
      if (Reset) begin
         addr_r <= 18'd0;
         data_r <= 16'd0;
         we_n_r <= 1'b1;
      end else if (xfer_s) begin
         addr_r <= addr_s;
         data_r <= deq_s;
         we_n_r <= 1'b0;
      end else begin
         we_n_r <= 1'b1;
      end
   end

   assign coeff_ready     = ready_r;
   assign SRAM_address    = addr_r;
   assign SRAM_write_data = data_r;
   assign SRAM_we_n       = we_n_r;
   assign Done            = done_r;

endmodule

// File: tb/tb_milestone3_dequant_writer.sv
// Bench for milestone3_dequant_writer: table of single-coefficient vectors, mid-block reset,
// and a frame walk (block rows reduced to keep run time short) checked by a write scoreboard.
`timescale 1ns/1ps
module tb_milestone3_dequant_writer;

   localparam int TB_ROWS = 2;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Enable;
   logic        Q_select;
   logic        coeff_valid;
   logic [15:0] coeff_data;
   logic        coeff_ready;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;
   logic        Done;

   milestone3_dequant_writer #(.BLK_ROWS(TB_ROWS)) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .Q_select(Q_select),
      .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ready(coeff_ready),
      .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
      .SRAM_we_n(SRAM_we_n), .Done(Done)
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [17:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic        q;
      int          blk;
      int          k;
      logic [15:0] d;
      logic [17:0] exp_addr;
      logic [15:0] exp_data;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs[NV];
   wr_t  sb_q[$];
   wr_t  mon_w;
   wr_t  tgt;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   bit exp_ready = 1'b0;
   bit xfer_next = 1'b0;
   bit mon_en = 1'b0;
   logic exp_we_n_q = 1'b1;
   logic [15:0] fd;

   int zz_tab[64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                      12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                      35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                      58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};
   int q0_tab[15] = '{3, 2, 3, 4, 5, 5, 6, 6, 6, 6, 6, 6, 6, 6, 6};
   int q1_tab[15] = '{3, 1, 1, 1, 2, 2, 3, 3, 4, 4, 4, 5, 5, 5, 5};

   function automatic wr_t model(input logic q, input int seg, input int br, input int bc,
                                 input int k, input logic [15:0] d);
      wr_t    w;
      int     p, r, c, s, base, stride;
      longint v;
      p = zz_tab[k];
      r = p / 8;
      c = p % 8;
      s = q ? q1_tab[r + c] : q0_tab[r + c];
      base   = (seg == 0) ? 76800 : ((seg == 1) ? 153600 : 192000);
      stride = (seg == 0) ? 320 : 160;
      w.addr = 18'(base + (br * 8 + r) * stride + bc * 8 + c);
      v = longint'($signed(d)) * (longint'(1) << s);
`ifdef DEQ_SATURATE_EN
      if (v > 32767) v = 32767;
      else if (v < -32768) v = -32768;
`endif
      w.data = 16'(v);
      return w;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   // A write must appear exactly one cycle after each transfer, in order
   always @(posedge Clock) exp_we_n_q <= ~xfer_next;

   always @(negedge Clock) begin
      if (mon_en) begin
         checks++;
         if (SRAM_we_n !== exp_we_n_q) begin
            errors++;
            $display("FAIL we_n got %b want %b at %0t", SRAM_we_n, exp_we_n_q, $time);
         end
         if (SRAM_we_n === 1'b0) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write addr %0d at %0t", SRAM_address, $time);
            end else begin
               mon_w = sb_q.pop_front();
               if (SRAM_address !== mon_w.addr || SRAM_write_data !== mon_w.data) begin
                  errors++;
                  $display("FAIL write got %0d/%h want %0d/%h at %0t", SRAM_address,
                           SRAM_write_data, mon_w.addr, mon_w.data, $time);
               end
            end
         end
         if (Done === 1'b1) done_cnt++;
      end
   end

   task automatic send(input logic [15:0] d, input wr_t exp, input bit rnd);
      int gap;
      gap = rnd ? int'($urandom_range(2, 0)) : 0;
      for (int i = 0; i < gap; i++) begin
         coeff_valid = 1'b0;
         coeff_data  = 16'($urandom);
         xfer_next   = 1'b0;
         @(posedge Clock); #1;
      end
      chk("ready", {31'd0, coeff_ready}, {31'd0, exp_ready});
      coeff_valid = 1'b1;
      coeff_data  = d;
      xfer_next   = exp_ready;
      if (exp_ready) sb_q.push_back(exp);
      @(posedge Clock); #1;
      coeff_valid = 1'b0;
      xfer_next   = 1'b0;
   endtask

   task automatic do_reset();
      Reset       = 1'b1;
      Enable      = 1'b0;
      coeff_valid = 1'b0;
      xfer_next   = 1'b0;
      exp_ready   = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;
      sb_q.delete();
   endtask

   task automatic start(input logic q);
      Q_select = q;
      Enable   = 1'b1;
      @(posedge Clock); #1;
      Enable    = 1'b0;
      Q_select  = ~q;
      exp_ready = 1'b1;
   endtask

   initial begin
      Reset = 1'b1; Enable = 1'b0; Q_select = 1'b0; coeff_valid = 1'b0; coeff_data = 16'd0;

      vecs[0] = '{1'b0, 0,  0, 16'd5,     18'd76800, 16'd40};
      vecs[1] = '{1'b0, 0,  1, 16'hFFFD,  18'd76801, 16'hFFF4};
      vecs[2] = '{1'b0, 0,  2, 16'd1,     18'd77120, 16'd4};
      vecs[3] = '{1'b1, 40, 0, 16'd1,     18'd79360, 16'd8};
      vecs[5] = '{1'b1, 0, 63, 16'hFFFF,  18'd79047, 16'hFFE0};
`ifdef DEQ_SATURATE_EN
      vecs[4] = '{1'b0, 0, 63, 16'h4000,  18'd79047, 16'h7FFF};
      vecs[6] = '{1'b1, 0,  5, 16'h7FFF,  18'd76802, 16'h7FFF};
      vecs[7] = '{1'b0, 1,  0, 16'h8000,  18'd76808, 16'h8000};
`else
      vecs[4] = '{1'b0, 0, 63, 16'h4000,  18'd79047, 16'h0000};
      vecs[6] = '{1'b1, 0,  5, 16'h7FFF,  18'd76802, 16'hFFFE};
      vecs[7] = '{1'b0, 1,  0, 16'h8000,  18'd76808, 16'h0000};
`endif

      repeat (2) @(posedge Clock);
      #1;
      chk("rst_addr",  32'(SRAM_address), 32'd0);
      chk("rst_data",  32'(SRAM_write_data), 32'd0);
      chk("rst_we_n",  {31'd0, SRAM_we_n}, 32'd1);
      chk("rst_ready", {31'd0, coeff_ready}, 32'd0);
      chk("rst_done",  {31'd0, Done}, 32'd0);
      mon_en = 1'b1;

      for (int i = 0; i < NV; i++) begin
         do_reset();
         start(vecs[i].q);
         for (int j = 0; j < vecs[i].blk * 64 + vecs[i].k; j++) begin
            fd = 16'($urandom_range(15, 0)) - 16'd8;
            send(fd, model(vecs[i].q, 0, (j / 64) / 40, (j / 64) % 40, j % 64, fd), 1'b0);
         end
         tgt.addr = vecs[i].exp_addr;
         tgt.data = vecs[i].exp_data;
         send(vecs[i].d, tgt, 1'b0);
         repeat (2) @(posedge Clock);
         #1;
         chk("vec_drained", sb_q.size(), 32'd0);
      end

      do_reset();
      start(1'b0);
      for (int j = 0; j < 20; j++) begin
         fd = 16'($urandom);
         send(fd, model(1'b0, 0, 0, 0, j, fd), 1'b1);
      end
      Reset       = 1'b1;
      coeff_valid = 1'b1;
      coeff_data  = 16'h0123;
      exp_ready   = 1'b0;
      @(posedge Clock); #1;
      chk("midrst_we_n",  {31'd0, SRAM_we_n}, 32'd1);
      chk("midrst_ready", {31'd0, coeff_ready}, 32'd0);
      chk("midrst_addr",  32'(SRAM_address), 32'd0);
      chk("midrst_drained", sb_q.size(), 32'd0);
      Reset       = 1'b0;
      coeff_valid = 1'b0;
      @(posedge Clock); #1;
      start(1'b0);
      tgt.addr = 18'd76800;
      tgt.data = 16'd40;
      send(16'd5, tgt, 1'b0);
      repeat (2) @(posedge Clock);
      #1;
      chk("restart_drained", sb_q.size(), 32'd0);

      do_reset();
      start(1'b0);
      for (int seg = 0; seg < 3; seg++) begin
         for (int br = 0; br < TB_ROWS; br++) begin
            for (int bc = 0; bc < ((seg == 0) ? 40 : 20); bc++) begin
               for (int k = 0; k < 64; k++) begin
                  fd = 16'($urandom);
                  if (k == 5) begin
                     Enable   = 1'b1;
                     Q_select = 1'b1;
                  end
                  send(fd, model(1'b0, seg, br, bc, k, fd), 1'b1);
                  Enable = 1'b0;
                  if (seg > 0 && br == 0 && bc == 0 && k == 0) begin
                     chk("seg_first_addr", 32'(SRAM_address), (seg == 1) ? 32'd153600 : 32'd192000);
                     chk("seg_first_we_n", {31'd0, SRAM_we_n}, 32'd0);
                  end
               end
            end
         end
      end
      exp_ready = 1'b0;
      chk("last_addr", 32'(SRAM_address), 32'(192000 + ((TB_ROWS - 1) * 8 + 7) * 160 + 159));
      chk("done_n1", {31'd0, Done}, 32'd0);
      chk("flush_ready", {31'd0, coeff_ready}, 32'd0);
      @(posedge Clock); #1;
      chk("done_n2", {31'd0, Done}, 32'd1);
      @(posedge Clock); #1;
      chk("done_n3", {31'd0, Done}, 32'd0);
      repeat (3) @(posedge Clock);
      #1;
      chk("done_count", done_cnt, 32'd1);
      chk("frame_drained", sb_q.size(), 32'd0);
      chk("idle_ready", {31'd0, coeff_ready}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
